// File: rtl/adp_bscan_engine_pkg.sv
// Shared types and constants for the boundary-scan engine and its cells.
package adp_bscan_engine_pkg;

  localparam int unsigned NUM_BOUNDARY_CELLS = 49;

  typedef enum logic [1:0] {
    OP_SAMPLE  = 2'd0,
    OP_PRELOAD = 2'd1,
    OP_EXTEST  = 2'd2,
    OP_CLEAR   = 2'd3
  } adp_bscan_op_t;

  typedef enum logic [1:0] {
    CELL_IN  = 2'd0,
    CELL_OUT = 2'd1,
    CELL_TRI = 2'd2
  } adp_bscan_cell_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_RESP    = 3'd5
  } adp_bscan_state_t;

  // Update-latch reset value: only TRI cells start disabled; anything else (incl. illegal) is 0.
  function automatic logic cell_reset_val(input logic [1:0] cell_type, input logic tri_safe);
    return (cell_type == 2'(CELL_TRI)) ? tri_safe : 1'b0;
  endfunction

endpackage

// File: rtl/adp_bscan_engine_cell.sv
// One boundary cell: shift flop, update latch and functional/test output mux.
module adp_bscan_cell
  import adp_bscan_engine_pkg::*;
#(
  parameter logic [1:0] CELL_TYPE = 2'(CELL_IN),
  parameter logic       SAFE_VAL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic test_mode,
  input  logic capture_en,
  input  logic shift_en,
  input  logic update_en,
  input  logic clear_en,
  input  logic shift_in,
  input  logic func_in,
  output logic scan_out,
  output logic func_out
);

  localparam logic UR_RST = cell_reset_val(CELL_TYPE, SAFE_VAL);

  if (CELL_TYPE == 2'd3) begin : g_illegal_type
    $warning("adp_bscan_cell: illegal cell type 3, behaves as IN");
  end

  logic sr_q, sr_d;
  logic ur_q, ur_d;

  always_comb begin
    sr_d = sr_q;
    ur_d = ur_q;
    if (clear_en) begin
      sr_d = 1'b0;
      ur_d = UR_RST;
    end else begin
      if (capture_en)    sr_d = func_in;
      else if (shift_en) sr_d = shift_in;
      if (update_en)     ur_d = sr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= 1'b0;
      ur_q <= UR_RST;
    end else begin
      sr_q <= sr_d;
      ur_q <= ur_d;
    end
  end

  assign scan_out = sr_q;
  assign func_out = test_mode ? ur_q : func_in;

endmodule

// File: rtl/adp_bscan_engine.sv
// Boundary-scan chain with on-chip capture/shift/update sequencer and valid/ready command/response.
module adp_bscan_engine
  import adp_bscan_engine_pkg::*;
#(
  parameter int unsigned              NUM_CELLS  = NUM_BOUNDARY_CELLS,
  parameter logic [2*NUM_CELLS-1:0]   CELL_TYPES = '0,
  parameter logic                     TRI_SAFE   = 1'b1
) (
  input  logic                 adp_bscan_clk,
  input  logic                 adp_bscan_rst_n,
  input  logic                 test_mode,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  adp_bscan_op_t        cmd_op,
  input  logic [NUM_CELLS-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NUM_CELLS-1:0] rsp_data,
  output logic                 busy,
  output logic                 scan_so,
  input  logic [NUM_CELLS-1:0] func_in,
  output logic [NUM_CELLS-1:0] func_out
);

  localparam int unsigned CNT_W = $clog2(NUM_CELLS + 1);

  if (NUM_CELLS < 2) begin : g_bad_num_cells
    $error("adp_bscan_engine: NUM_CELLS must be >= 2");
  end

  adp_bscan_state_t     state_q, state_d;
  adp_bscan_op_t        op_q, op_d;
  logic [NUM_CELLS-1:0] pat_q, pat_d;
  logic [NUM_CELLS-1:0] out_q, out_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 busy_q, busy_d;

  logic                 cap_en, shift_en, upd_en, clr_en;
  logic [NUM_CELLS-1:0] sr;
  logic [NUM_CELLS-1:0] chain_in;

  // Pattern enters at the top cell; the chain moves toward cell 0 (LSB out first).
  assign chain_in = {pat_q[0], sr[NUM_CELLS-1:1]};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pat_d       = pat_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    cap_en      = 1'b0;
    shift_en    = 1'b0;
    upd_en      = 1'b0;
    clr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d  = cmd_op;
          pat_d = cmd_data;
          cnt_d = '0;
          case (cmd_op)
            OP_SAMPLE:  state_d = ST_CAPTURE;
            OP_PRELOAD: state_d = ST_SHIFT;
            OP_EXTEST:  state_d = ST_CAPTURE;
            OP_CLEAR:   state_d = ST_CLEAR;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
      ST_CAPTURE: begin
        cap_en  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        pat_d    = pat_q >> 1;
        out_d    = {sr[0], out_q[NUM_CELLS-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_CELLS - 1)) begin
          if (op_q == OP_SAMPLE) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        upd_en      = 1'b1;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      ST_CLEAR: begin
        clr_en      = 1'b1;
        out_d       = '0;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge adp_bscan_clk or negedge adp_bscan_rst_n) begin
    if (!adp_bscan_rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SAMPLE;
      pat_q       <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pat_q       <= pat_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    adp_bscan_cell #(
      .CELL_TYPE (CELL_TYPES[2*i +: 2]),
      .SAFE_VAL  (TRI_SAFE)
    ) u_cell (
      .clk        (adp_bscan_clk),
      .rst_n      (adp_bscan_rst_n),
      .test_mode  (test_mode),
      .capture_en (cap_en),
      .shift_en   (shift_en),
      .update_en  (upd_en),
      .clear_en   (clr_en),
      .shift_in   (chain_in[i]),
      .func_in    (func_in[i]),
      .scan_out   (sr[i]),
      .func_out   (func_out[i])
    );
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = out_q;
  assign busy      = busy_q;
  assign scan_so   = sr[0];

endmodule

// File: tb/tb_adp_bscan_engine.sv
// Self-checking bench for adp_bscan_engine: 8 cells IN,IN,OUT,OUT,TRI,TRI,OUT,IN.
module tb_adp_bscan_engine;
  import adp_bscan_engine_pkg::*;

  localparam int unsigned N = 8;
  localparam logic [2*N-1:0] TYPES = 16'h1A50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          test_mode;
  logic          cmd_valid;
  logic          cmd_ready;
  adp_bscan_op_t cmd_op;
  logic [N-1:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          busy;
  logic          scan_so;
  logic [N-1:0]  func_in;
  logic [N-1:0]  func_out;

  adp_bscan_engine #(
    .NUM_CELLS  (N),
    .CELL_TYPES (TYPES),
    .TRI_SAFE   (1'b1)
  ) dut (
    .adp_bscan_clk   (clk),
    .adp_bscan_rst_n (rst_n),
    .test_mode       (test_mode),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .busy            (busy),
    .scan_so         (scan_so),
    .func_in         (func_in),
    .func_out        (func_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    adp_bscan_op_t op;
    logic [N-1:0]  data;
    logic [N-1:0]  fin;
    logic [N-1:0]  exp_rsp;
    logic [N-1:0]  exp_fout;
    int            exp_lat;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for rsp_valid; returns cycles since accept, or -1 on timeout.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic handshake_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cmd_ready", cmd_ready, 1'b1);
  endtask

  // Entered at a negedge with the engine idle.
  task automatic run(input vec_t v);
    int           lat;
    logic [N-1:0] exp;
    func_in   = v.fin;
    cmd_op    = v.op;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    sb_q.push_back(v.exp_rsp);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("cmd_ready_busy", cmd_ready, 1'b0);
    wait_rsp(lat);
    chk("latency", 32'(lat), 32'(v.exp_lat));
    if (lat < 0) return;
    exp = sb_q.pop_front();
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    chk("func_out_test", 32'(func_out), 32'(v.exp_fout));
    chk("scan_so", scan_so, (v.op == OP_CLEAR) ? 1'b0 : v.data[0]);
    test_mode = 1'b0;
    #1;
    chk("func_out_transparent", 32'(func_out), 32'(v.fin));
    test_mode = 1'b1;
    handshake_rsp();
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    int seen;
    logic [N-1:0] exp;

    vecs[0] = '{OP_PRELOAD, 8'hA5, 8'h00, 8'h00, 8'hA5, 10};
    vecs[1] = '{OP_EXTEST,  8'h3C, 8'h96, 8'h96, 8'h3C, 11};
    vecs[2] = '{OP_SAMPLE,  8'hC3, 8'h5A, 8'h5A, 8'h3C, 10};
    vecs[3] = '{OP_PRELOAD, 8'h0F, 8'h00, 8'hC3, 8'h0F, 10};
    vecs[4] = '{OP_CLEAR,   8'hFF, 8'h00, 8'h00, 8'h30, 2};
    vecs[5] = '{OP_PRELOAD, 8'h81, 8'h00, 8'h00, 8'h81, 10};
    vecs[6] = '{OP_SAMPLE,  8'h55, 8'hE7, 8'hE7, 8'h81, 10};

    rst_n = 1'b0; test_mode = 1'b1; cmd_valid = 1'b0; cmd_op = OP_SAMPLE;
    cmd_data = '0; rsp_ready = 1'b0; func_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_func_out", 32'(func_out), 32'h30);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_rsp_valid", rsp_valid, 1'b0);
    chk("rel_busy", busy, 1'b0);
    chk("rel_scan_so", scan_so, 1'b0);
    chk("rel_rsp_data", 32'(rsp_data), 32'h0);
    chk("rel_func_out", 32'(func_out), 32'h30);

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Response back-pressure with the next command already waiting.
    func_in = 8'h3A; cmd_op = OP_SAMPLE; cmd_data = 8'h12; cmd_valid = 1'b1;
    chk("hold_ready0", cmd_ready, 1'b1);
    sb_q.push_back(8'h3A);
    @(negedge clk);
    cmd_op = OP_PRELOAD; cmd_data = 8'h44;
    wait_rsp(lat);
    chk("hold_latency", 32'(lat), 32'd10);
    exp = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_data", 32'(rsp_data), 32'(exp));
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_cmd_ready", cmd_ready, 1'b1);
    sb_q.push_back(8'h12);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    wait_rsp(lat);
    chk("b2b_latency", 32'(lat), 32'd10);
    exp = sb_q.pop_front();
    chk("b2b_rsp_data", 32'(rsp_data), 32'(exp));
    chk("b2b_func_out", 32'(func_out), 32'h44);
    handshake_rsp();

    // Reset in the middle of an EXTEST shift (count 3).
    func_in = 8'h00; cmd_op = OP_EXTEST; cmd_data = 8'h77; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_func_out", 32'(func_out), 32'h30);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_scan_so", scan_so, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);

    run('{OP_PRELOAD, 8'h11, 8'h00, 8'h00, 8'h11, 10});
    run('{OP_CLEAR,   8'h00, 8'h00, 8'h00, 8'h30, 2});
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
